// File: rtl/exec_core_seq_pkg.sv
// Shared definitions for exec_core_seq: opcode map, FSM state encoding.
// Instruction layout: [op | dst | src1 | src2]; LD/ST/STI use the low ADDR_W bits as address.
package exec_core_seq_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_HLT  = 4'h1;
   localparam logic [3:0] OP_MV   = 4'h2;
   localparam logic [3:0] OP_LD   = 4'h3;
   localparam logic [3:0] OP_LDI  = 4'h4;
   localparam logic [3:0] OP_ST   = 4'h5;
   localparam logic [3:0] OP_STI  = 4'h6;
   localparam logic [3:0] OP_ADD  = 4'h8;
   localparam logic [3:0] OP_ADDI = 4'h9;
   localparam logic [3:0] OP_SUB  = 4'hA;
   localparam logic [3:0] OP_SUBI = 4'hB;
   localparam logic [3:0] OP_MUL  = 4'hC;
   localparam logic [3:0] OP_MULI = 4'hD;
   localparam logic [3:0] OP_DIV  = 4'hE;
   localparam logic [3:0] OP_DIVI = 4'hF;

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_FETCH   = 4'd1;
   localparam logic [3:0] S_DECODE  = 4'd2;
   localparam logic [3:0] S_IMM     = 4'd3;
   localparam logic [3:0] S_MEMOP   = 4'd4;
   localparam logic [3:0] S_AUOP    = 4'd5;
   localparam logic [3:0] S_AU_WAIT = 4'd6;
   localparam logic [3:0] S_HALTED  = 4'd7;
   localparam logic [3:0] S_TRAP    = 4'd8;

endpackage

// File: rtl/exec_core_regfile.sv
// Register bank for exec_core_seq: two async read ports, one sync write port, async clear.
// With EXEC_CORE_DBG_EN a third async read port serves the debug interface.
module exec_core_regfile #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned REG_AW = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [REG_AW-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata
`ifdef EXEC_CORE_DBG_EN
   ,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
`endif
);

   localparam int unsigned NREG = 2**REG_AW;

   logic [DATA_W-1:0] regs [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign ra_data = regs[ra_addr];
   assign rb_data = regs[rb_addr];
`ifdef EXEC_CORE_DBG_EN
   assign dbg_data = regs[dbg_addr];
`endif

endmodule

// File: rtl/exec_core_seq.sv
// Multi-cycle fetch/decode/execute core with memory req/ack and AU start/done handshakes.
// Optional debug port and retired-instruction counter: define EXEC_CORE_DBG_EN.
module exec_core_seq import exec_core_seq_pkg::*; #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned REG_AW = 4,
   parameter int unsigned OPC_W  = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              halted,
   output logic              illegal,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              au_start,
   output logic [OPC_W-1:0]  au_mode,
   output logic [DATA_W-1:0] au_a,
   output logic [DATA_W-1:0] au_b,
   input  logic              au_done,
   input  logic [DATA_W-1:0] au_result
`ifdef EXEC_CORE_DBG_EN
   ,
   input  logic [REG_AW-1:0] dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [31:0]       retired
`endif
);

   logic [3:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir, st_data, au_a_q, au_b_q;
   logic [OPC_W-1:0]  op;
   logic [REG_AW-1:0] dst, src1, src2, ra_addr;
   logic [DATA_W-1:0] ra_data, rb_data, rf_wdata;
   logic              rf_we, is_au;

   assign op    = ir[DATA_W-1 -: OPC_W];
   assign dst   = ir[DATA_W-OPC_W-1 -: REG_AW];
   assign src1  = ir[DATA_W-OPC_W-REG_AW-1 -: REG_AW];
   assign src2  = ir[DATA_W-OPC_W-2*REG_AW-1 -: REG_AW];
   assign is_au = op[OPC_W-1];
   // port A doubles as the store-data read so only two ports are needed
   assign ra_addr = (op == OP_ST) ? dst : src1;

   always_comb begin
      rf_we    = 1'b0;
      rf_wdata = mem_rdata;
      case (state)
         S_DECODE:  if (op == OP_MV) begin rf_we = 1'b1; rf_wdata = ra_data; end
         S_IMM:     rf_we = mem_ack && (op == OP_LDI);
         S_MEMOP:   rf_we = mem_ack && (op == OP_LD);
         S_AU_WAIT: if (au_done) begin rf_we = 1'b1; rf_wdata = au_result; end
         default:   rf_we = 1'b0;
      endcase
   end

   exec_core_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .ra_addr (ra_addr),
      .ra_data (ra_data),
      .rb_addr (src2),
      .rb_data (rb_data),
      .we      (rf_we),
      .waddr   (dst),
      .wdata   (rf_wdata)
`ifdef EXEC_CORE_DBG_EN
      ,
      .dbg_addr(dbg_raddr),
      .dbg_data(dbg_rdata)
`endif
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         pc      <= RESET_PC;
         ir      <= '0;
         st_data <= '0;
         au_a_q  <= '0;
         au_b_q  <= '0;
      end else begin
         case (state)
            S_IDLE, S_HALTED, S_TRAP: if (start) begin
               state <= S_FETCH;
               pc    <= RESET_PC;
            end
            S_FETCH: if (mem_ack) begin
               ir    <= mem_rdata;
               pc    <= pc + ADDR_W'(1);
               state <= S_DECODE;
            end
            S_DECODE: begin
               if (op == OP_ST) st_data <= ra_data;
               if (is_au) begin
                  au_a_q <= ra_data;
                  if (!op[0]) au_b_q <= rb_data;
                  state <= op[0] ? S_IMM : S_AUOP;
               end else begin
                  case (op)
                     OP_NOP, OP_MV:  state <= S_FETCH;
                     OP_HLT:         state <= S_HALTED;
                     OP_LD, OP_ST:   state <= S_MEMOP;
                     OP_LDI, OP_STI: state <= S_IMM;
                     default:        state <= S_TRAP;
                  endcase
               end
            end
            S_IMM: if (mem_ack) begin
               pc <= pc + ADDR_W'(1);
               if (is_au) begin
                  au_b_q <= mem_rdata;
                  state  <= S_AUOP;
               end else if (op == OP_STI) begin
                  st_data <= mem_rdata;
                  state   <= S_MEMOP;
               end else begin
                  state <= S_FETCH;
               end
            end
            S_MEMOP:   if (mem_ack) state <= S_FETCH;
            S_AUOP:    state <= S_AU_WAIT;
            S_AU_WAIT: if (au_done) state <= S_FETCH;
            default:   state <= S_IDLE;
         endcase
      end
   end

   assign busy      = !(state == S_IDLE || state == S_HALTED || state == S_TRAP);
   assign halted    = (state == S_HALTED);
   assign illegal   = (state == S_TRAP);
   assign mem_req   = (state == S_FETCH) || (state == S_IMM) || (state == S_MEMOP);
   assign mem_we    = (state == S_MEMOP) && (op == OP_ST || op == OP_STI);
   assign mem_addr  = (state == S_MEMOP) ? ir[ADDR_W-1:0] : (mem_req ? pc : '0);
   assign mem_wdata = mem_we ? st_data : '0;
   assign au_start  = (state == S_AUOP);
   assign au_mode   = (state == S_AUOP || state == S_AU_WAIT) ? {op[OPC_W-1:1], 1'b0} : '0;
   assign au_a      = au_a_q;
   assign au_b      = au_b_q;

`ifdef EXEC_CORE_DBG_EN
   logic retire;
   assign retire = ((state == S_DECODE) && (op == OP_NOP || op == OP_MV || op == OP_HLT))
                || ((state == S_IMM) && mem_ack && (op == OP_LDI))
                || ((state == S_MEMOP) && mem_ack)
                || ((state == S_AU_WAIT) && au_done);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired <= '0;
      end else if (start && !busy) begin
         retired <= '0;
      end else if (retire && retired != '1) begin
         retired <= retired + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_exec_core_seq.sv
// Scoreboard bench for exec_core_seq: memory and AU models with programmable wait states.
module tb_exec_core_seq;
   localparam logic [7:0] RPC = 8'hFE;

   logic        clk, rst_n, start;
   logic        busy, halted, illegal;
   logic        mem_req, mem_we, mem_ack;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        au_start, au_done;
   logic [3:0]  au_mode;
   logic [15:0] au_a, au_b, au_result;
`ifdef EXEC_CORE_DBG_EN
   logic [3:0]  dbg_raddr;
   logic [15:0] dbg_rdata;
   logic [31:0] retired;
`endif

   exec_core_seq #(.DATA_W(16), .ADDR_W(8), .REG_AW(4), .OPC_W(4), .RESET_PC(RPC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .halted(halted), .illegal(illegal),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .au_start(au_start), .au_mode(au_mode), .au_a(au_a), .au_b(au_b),
      .au_done(au_done), .au_result(au_result)
`ifdef EXEC_CORE_DBG_EN
      , .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .retired(retired)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_total = 0, n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   typedef struct { logic [7:0] addr; logic [15:0] data; } wr_t;
   typedef struct { logic [3:0] mode; logic [15:0] a; logic [15:0] b; } au_t;
   wr_t exp_wr[$];
   au_t exp_au[$];

   logic [15:0] mem [256];
   int unsigned mem_delay = 0, au_delay = 0, n_au_start = 0;

   task automatic put(input int unsigned k, input logic [15:0] w);
      mem[8'(32'(RPC) + k)] = w;
   endtask

   task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
      wr_t e;
      e.addr = a; e.data = d;
      exp_wr.push_back(e);
   endtask

   task automatic push_au(input logic [3:0] m, input logic [15:0] a, input logic [15:0] b);
      au_t e;
      e.mode = m; e.a = a; e.b = b;
      exp_au.push_back(e);
   endtask

   // memory: ack arrives mem_delay+1 cycles after req is first seen
   initial begin : mem_model
      int unsigned mcnt;
      logic [7:0]  s_addr;
      logic        s_we;
      logic [15:0] s_wd;
      wr_t         e;
      mem_ack = 1'b0; mem_rdata = '0; mcnt = 0;
      forever begin
         @(posedge clk); #1;
         mem_ack = 1'b0;
         if (!rst_n || !mem_req) begin
            mcnt = 0;
         end else begin
            if (mcnt == 0) begin s_addr = mem_addr; s_we = mem_we; s_wd = mem_wdata; end
            if (mcnt >= mem_delay + 1) begin
               mem_ack = 1'b1;
               mcnt = 0;
               if (mem_delay > 0) begin
                  check_val("mem_addr_stable", 32'(mem_addr), 32'(s_addr));
                  check_val("mem_we_stable", 32'(mem_we), 32'(s_we));
                  check_val("mem_wdata_stable", 32'(mem_wdata), 32'(s_wd));
               end
               if (mem_we) begin
                  mem[mem_addr] = mem_wdata;
                  if (exp_wr.size() == 0) begin
                     check_val("wr_expected_pending", 32'(exp_wr.size()), 32'd1);
                  end else begin
                     e = exp_wr.pop_front();
                     check_val("wr_addr", 32'(mem_addr), 32'(e.addr));
                     check_val("wr_data", 32'(mem_wdata), 32'(e.data));
                  end
               end else begin
                  mem_rdata = mem[mem_addr];
               end
            end else begin
               mcnt++;
            end
         end
      end
   end

   // arithmetic unit: done arrives au_delay+1 cycles after start; ignores reset on purpose
   initial begin : au_model
      logic        pend;
      int unsigned rem;
      logic [15:0] res, s_a, s_b;
      logic [3:0]  s_mode;
      au_t         e;
      au_done = 1'b0; au_result = '0; pend = 1'b0; rem = 0; res = '0;
      forever begin
         @(posedge clk); #1;
         au_done = 1'b0;
         if (au_start) n_au_start++;
         if (pend) begin
            if (rem == 0) begin
               au_done = 1'b1; au_result = res; pend = 1'b0;
               if (busy) begin
                  check_val("au_mode_stable", 32'(au_mode), 32'(s_mode));
                  check_val("au_a_stable", 32'(au_a), 32'(s_a));
                  check_val("au_b_stable", 32'(au_b), 32'(s_b));
               end
            end else begin
               rem--;
            end
         end else if (au_start) begin
            pend = 1'b1; rem = au_delay;
            s_mode = au_mode; s_a = au_a; s_b = au_b;
            case (au_mode)
               4'h8:    res = au_a + au_b;
               4'hA:    res = au_a - au_b;
               4'hC:    res = au_a * au_b;
               4'hE:    res = (au_b == 0) ? 16'hFFFF : au_a / au_b;
               default: res = 16'h0;
            endcase
            if (exp_au.size() == 0) begin
               check_val("au_expected_pending", 32'(exp_au.size()), 32'd1);
            end else begin
               e = exp_au.pop_front();
               check_val("au_mode", 32'(au_mode), 32'(e.mode));
               check_val("au_a", 32'(au_a), 32'(e.a));
               check_val("au_b", 32'(au_b), 32'(e.b));
            end
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_prog(input string tag, output int unsigned cyc);
      pulse_start();
      cyc = 0;
      while (busy && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_val({tag, "_finished"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int unsigned cyc, n0;
      rst_n = 1'b0; start = 1'b0;
`ifdef EXEC_CORE_DBG_EN
      dbg_raddr = '0;
`endif
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_halted", 32'(halted), 32'd0);
      check_val("rst_illegal", 32'(illegal), 32'd0);
      check_val("rst_mem_req", 32'(mem_req), 32'd0);
      check_val("rst_mem_addr", 32'(mem_addr), 32'd0);
      check_val("rst_au_start", 32'(au_start), 32'd0);
      rst_n = 1'b1;

      // LDI across PC wrap (imm at 0xFF, next fetch 0x00), then ADD and store
      put(0, 16'h4100); put(1, 16'h0005); put(2, 16'h4200); put(3, 16'h0003);
      put(4, 16'h8312); put(5, 16'h5340); put(6, 16'h1000);
      push_au(4'h8, 16'h0005, 16'h0003);
      push_wr(8'h40, 16'h0008);
      run_prog("t1", cyc);
      check_val("t1_halted", 32'(halted), 32'd1);
      check_val("t1_illegal", 32'(illegal), 32'd0);
      check_val("t1_latency", cyc, 32'd23);

      // ST / LD / ST with 3 wait states on every memory access
      mem_delay = 3;
      put(0, 16'h5342); put(1, 16'h3442); put(2, 16'h5443); put(3, 16'h1000);
      push_wr(8'h42, 16'h0008);
      push_wr(8'h43, 16'h0008);
      run_prog("t2", cyc);
      check_val("t2_halted", 32'(halted), 32'd1);
      mem_delay = 0;

      // ADDI with a slow AU: exactly one au_start pulse
      au_delay = 10;
      n0 = n_au_start;
      put(0, 16'h4500); put(1, 16'h0010); put(2, 16'h9550); put(3, 16'h0001);
      put(4, 16'h5544); put(5, 16'h1000);
      push_au(4'h8, 16'h0010, 16'h0001);
      push_wr(8'h44, 16'h0011);
      run_prog("t3", cyc);
      check_val("t3_au_start_pulses", n_au_start - n0, 32'd1);
      au_delay = 0;

      // MV, SUBI, MUL, DIV, STI, ST, NOP
      put(0, 16'h2650); put(1, 16'hB760); put(2, 16'h0003); put(3, 16'hC871);
      put(4, 16'hE982); put(5, 16'h6045); put(6, 16'hBEEF); put(7, 16'h5846);
      put(8, 16'h5947); put(9, 16'h0000); put(10, 16'h1000);
      push_au(4'hA, 16'h0011, 16'h0003);
      push_au(4'hC, 16'h000E, 16'h0005);
      push_au(4'hE, 16'h0046, 16'h0003);
      push_wr(8'h45, 16'hBEEF);
      push_wr(8'h46, 16'h0046);
      push_wr(8'h47, 16'h0017);
      run_prog("t4", cyc);
      check_val("t4_latency", cyc, 32'd43);

      // illegal opcode trap, then restart from RESET_PC
      put(0, 16'h7000);
      run_prog("t5", cyc);
      check_val("t5_illegal", 32'(illegal), 32'd1);
      check_val("t5_halted", 32'(halted), 32'd0);
      put(0, 16'h1000);
      pulse_start();
      check_val("t5_illegal_cleared", 32'(illegal), 32'd0);
      check_val("t5_busy", 32'(busy), 32'd1);
      check_val("t5_restart_addr", 32'(mem_addr), 32'(RPC));
      cyc = 0;
      while (busy && cyc < 100) begin @(posedge clk); #1; cyc++; end
      check_val("t5_rerun_halted", 32'(halted), 32'd1);

      // async reset while waiting on the AU; the late au_done must be ignored
      au_delay = 10;
      put(0, 16'h8312); put(1, 16'h1000);
      push_au(4'h8, 16'h0005, 16'h0003);
      pulse_start();
      cyc = 0;
      while (!au_start && cyc < 20) begin @(posedge clk); #1; cyc++; end
      check_val("t6_au_start_seen", 32'(au_start), 32'd1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check_val("t6_rst_busy", 32'(busy), 32'd0);
      check_val("t6_rst_mem_req", 32'(mem_req), 32'd0);
      check_val("t6_rst_au_mode", 32'(au_mode), 32'd0);
      check_val("t6_rst_au_a", 32'(au_a), 32'd0);
      check_val("t6_rst_au_b", 32'(au_b), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check_val("t6_spurious_busy", 32'(busy), 32'd0);
      check_val("t6_spurious_mem_req", 32'(mem_req), 32'd0);
      check_val("t6_spurious_halted", 32'(halted), 32'd0);
      au_delay = 0;
      put(0, 16'h5348); put(1, 16'h5149); put(2, 16'h1000);
      push_wr(8'h48, 16'h0000);
      push_wr(8'h49, 16'h0000);
      run_prog("t6", cyc);
      check_val("t6_halted", 32'(halted), 32'd1);

      check_val("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
      check_val("au_queue_drained", 32'(exp_au.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
